digest_serializer: RTL

DIGEST_SERIALIZER -- requirements
Module: digest_serializer

---
 rtl/sha2_pkg.sv | 24 ++
 rtl/digest_word_count.sv | 17 +
 rtl/digest_serializer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: mode encodings, datapath widths, TUSER slot layout
// and the serializer state encoding.
package sha2_pkg;

    localparam logic [1:0] SHA224 = 2'd0;
    localparam logic [1:0] SHA256 = 2'd1;
    localparam logic [1:0] SHA384 = 2'd2;
    localparam logic [1:0] SHA512 = 2'd3;

    localparam int WORD_WIDTH = 32;
    localparam int REG_WIDTH  = 64;

    // TUSER layout: mode field at the bottom, followed by the digest byte length.
    localparam int TUSER_MODE_OFFSET = 0;
    localparam int TUSER_MODE_WIDTH  = 2;
    localparam int TUSER_LEN_OFFSET  = 2;
    localparam int TUSER_LEN_WIDTH   = 7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/digest_word_count.sv
// Combinational decode of a beat's tkeep into the number of 32-bit words to emit:
// ceil((highest set byte index + 1) / 4), zero when no byte is kept.
module digest_word_count (
    input  logic [63:0] tkeep,
    output logic [4:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 64; i++) begin
            if (tkeep[i]) begin
                count = 5'((i / 4) + 1);
            end
        end
    end

endmodule

// File: rtl/digest_serializer.sv
// Serializes one digest beat into N 32-bit AXI-Stream words, word 0 first.
// Define DIGEST_BYTESWAP_EN to byte-reverse every output word.
module digest_serializer #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_M_AXIS_DATA_WIDTH  = 32,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              axis_aclk,
    input  logic                              reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready
);

    import sha2_pkg::*;

    ser_state_t                         r_state;
    ser_state_t                         w_state_nxt;
    ser_state_t                         w_state_cur;
    logic [C_S_AXIS_DATA_WIDTH-1:0]     r_data;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]    r_user;
    logic [4:0]                         r_cnt;
    logic [3:0]                         r_idx;
    logic [4:0]                         w_count;
    logic [WORD_WIDTH-1:0]              w_word;
    logic                               w_accept;
    logic                               w_fire;
    logic                               w_last;
    logic                               w_unused_tlast;

    function automatic logic [WORD_WIDTH-1:0] f_out_word(input logic [WORD_WIDTH-1:0] w);
`ifdef DIGEST_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Every accepted beat is a whole digest, so the framing bit carries no information.
    assign w_unused_tlast = s_axis_tlast;

    digest_word_count u_word_count (
        .tkeep (s_axis_tkeep),
        .count (w_count)
    );

    assign w_word      = r_data[{r_idx, 5'b0} +: WORD_WIDTH];
    assign w_last      = ({1'b0, r_idx} == (r_cnt - 5'd1));
    // Reset forces idle-state outputs immediately, not just from the next edge.
    assign w_state_cur = reset ? IDLE : r_state;

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_fire        = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        case (w_state_cur)
            IDLE: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && (w_count != 5'd0)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = f_out_word(w_word);
                m_axis_tkeep  = '1;
                m_axis_tuser  = r_user;
                m_axis_tlast  = w_last;
                if (m_axis_tready) begin
                    w_fire = 1'b1;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= w_count;
                r_idx <= '0;
            end else if (w_fire) begin
                r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (w_accept) begin
            r_data <= s_axis_tdata;
            r_user <= s_axis_tuser;
        end
    end

endmodule
